graycounter_sched: RTL and testbench

Command sequencer and two-port round-robin arbiter for the 3-bit up/down gray-code counter. It accepts LOAD, UP-n, DOWN-n and SEEK commands from two requesters and drives the counter's `up`/`load`/`in` controls cycle by cycle. When no command is executing, it holds the counter value by reloading `q` onto itself. It reports each completion with the final counter value.

---
 rtl/graycounter_sched.sv | 172 +++++++++++++++++
 tb/tb_graycounter_sched.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/graycounter_sched.sv
// graycounter_sched: two-port round-robin command sequencer for a W-bit
// up/down gray-code counter. It accepts LOAD / UP-n / DOWN-n / SEEK commands
// and drives the counter controls cycle by cycle. While idle, it holds the
// counter by reloading gc_q onto itself.
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   reqN_valid/ready      command handshake per requester (ready is combinational)
//   reqN_op, reqN_arg     00 LOAD, 01 UP, 10 DOWN, 11 SEEK; argument
//   gc_up/gc_load/gc_in   counter controls
//   gc_q                  counter output (gray)
//   busy                  not IDLE
//   done/done_id/done_q   one-cycle completion pulse, requester, final count
//   done_err              SEEK ran out of steps without a match
module graycounter_sched #(
  parameter int unsigned W          = 3,
  parameter int unsigned SEEK_LIMIT = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [1:0]   req0_op,
  input  logic [W-1:0] req0_arg,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [1:0]   req1_op,
  input  logic [W-1:0] req1_arg,
  output logic         gc_up,
  output logic         gc_load,
  output logic [W-1:0] gc_in,
  input  logic [W-1:0] gc_q,
  output logic         busy,
  output logic         done,
  output logic         done_id,
  output logic [W-1:0] done_q,
  output logic         done_err
);

  localparam int unsigned SLW = $clog2(SEEK_LIMIT + 1);
  localparam int unsigned CW  = (SLW > W) ? SLW : W;

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_UP   = 2'b01;
  localparam logic [1:0] OP_DOWN = 2'b10;
  localparam logic [1:0] OP_SEEK = 2'b11;

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t          state_q, state_d;
  logic [1:0]      op_q, op_d;
  logic [W-1:0]    arg_q, arg_d;
  logic            id_q, id_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            rr_q, rr_d;
  logic            err_q, err_d;
  logic            grant0, grant1;
  logic [1:0]      sel_op;
  logic [W-1:0]    sel_arg;

  // State and command registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      op_q    <= OP_LOAD;
      arg_q   <= '0;
      id_q    <= 1'b0;
      cnt_q   <= '0;
      rr_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      arg_q   <= arg_d;
      id_q    <= id_d;
      cnt_q   <= cnt_d;
      rr_q    <= rr_d;
      err_q   <= err_d;
    end
  end

  // Arbitration, sequencing and counter control
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    arg_d      = arg_q;
    id_d       = id_q;
    cnt_d      = cnt_q;
    rr_d       = rr_q;
    err_d      = err_q;
    gc_load    = 1'b1;
    gc_in      = gc_q;
    gc_up      = 1'b1;
    req0_ready = 1'b0;
    req1_ready = 1'b0;

    // rr names the requester that wins a tie
    grant0  = req0_valid & (~req1_valid | ~rr_q);
    grant1  = req1_valid & (~req0_valid |  rr_q);
    sel_op  = grant1 ? req1_op  : req0_op;
    sel_arg = grant1 ? req1_arg : req0_arg;

    case (state_q)
      IDLE: begin
        req0_ready = grant0;
        req1_ready = grant1;
        if (grant0 | grant1) begin
          id_d    = grant1;
          op_d    = sel_op;
          arg_d   = sel_arg;
          rr_d    = ~grant1;
          err_d   = 1'b0;
          // SEEK counts down its step budget; UP/DOWN count down the steps left
          cnt_d   = (sel_op == OP_SEEK) ? CW'(SEEK_LIMIT) : CW'(sel_arg);
          state_d = EXEC;
        end
      end
      EXEC: begin
        case (op_q)
          OP_LOAD: begin
            gc_in   = arg_q;
            state_d = DONE;
          end
          OP_UP, OP_DOWN: begin
            // the cycle after the last step is a hold, so gc_q has settled
            if (cnt_q != '0) begin
              gc_load = 1'b0;
              gc_up   = (op_q == OP_UP);
              cnt_d   = cnt_q - CW'(1);
            end else begin
              state_d = DONE;
            end
          end
          default: begin
            if (gc_q == arg_q) begin
              state_d = DONE;
            end else if (cnt_q == '0) begin
              err_d   = 1'b1;
              state_d = DONE;
            end else begin
              gc_load = 1'b0;
              cnt_d   = cnt_q - CW'(1);
            end
          end
        endcase
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Reset forces a load of zero and blocks any handshake
    if (reset) begin
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      gc_load    = 1'b1;
      gc_in      = '0;
      gc_up      = 1'b1;
    end
  end

  // Status outputs decoded from registered state
  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE) & ~reset;
  assign done_id  = id_q;
  assign done_q   = (state_q == DONE) ? gc_q : '0;
  assign done_err = (state_q == DONE) & err_q & ~reset;

endmodule

// File: tb/tb_graycounter_sched.sv
// Directed bench for graycounter_sched with a behavioural gray counter that
// can be frozen to force a SEEK timeout.
module tb_graycounter_sched;

  localparam int unsigned W = 3;
  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_UP   = 2'b01;
  localparam logic [1:0] OP_DOWN = 2'b10;
  localparam logic [1:0] OP_SEEK = 2'b11;

  logic         clk = 1'b0;
  logic         reset;
  logic         req0_valid, req0_ready, req1_valid, req1_ready;
  logic [1:0]   req0_op, req1_op;
  logic [W-1:0] req0_arg, req1_arg;
  logic         gc_up, gc_load;
  logic [W-1:0] gc_in, gc_q;
  logic         busy, done, done_id, done_err;
  logic [W-1:0] done_q;
  logic         stuck;

  int errors = 0;
  int checks = 0;

  graycounter_sched #(.W(W), .SEEK_LIMIT(8)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_arg(req0_arg),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_arg(req1_arg),
    .gc_up(gc_up), .gc_load(gc_load), .gc_in(gc_in), .gc_q(gc_q),
    .busy(busy), .done(done), .done_id(done_id), .done_q(done_q), .done_err(done_err)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] g2b(input logic [W-1:0] g);
    logic [W-1:0] b;
    b[W-1] = g[W-1];
    for (int i = W - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  function automatic logic [W-1:0] b2g(input logic [W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Gray counter model
  always_ff @(posedge clk) begin
    if (!stuck) begin
      if (gc_load) gc_q <= gc_in;
      else         gc_q <= b2g(gc_up ? g2b(gc_q) + W'(1) : g2b(gc_q) - W'(1));
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one command on a single requester; check latency and completion fields
  task automatic run_cmd(input bit id, input logic [1:0] op, input logic [W-1:0] arg,
                         input int exp_lat, input logic [W-1:0] exp_q, input bit exp_err,
                         input string tag);
    int n;
    if (id) begin req1_valid = 1'b1; req1_op = op; req1_arg = arg; end
    else    begin req0_valid = 1'b1; req0_op = op; req0_arg = arg; end
    #1;
    n = 0;
    while (((id ? req1_ready : req0_ready) !== 1'b1) && n < 8) begin step(); #1; n++; end
    chk({tag, "_ready"}, id ? req1_ready : req0_ready, 1);
    step();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    #1;
    if (op == OP_LOAD) begin
      chk({tag, "_load"}, gc_load, 1);
      chk({tag, "_gc_in"}, gc_in, arg);
    end
    n = 1;
    while (done !== 1'b1 && n < 40) begin step(); #1; n++; end
    chk({tag, "_latency"}, n, exp_lat);
    chk({tag, "_done_q"}, done_q, exp_q);
    chk({tag, "_done_id"}, done_id, id);
    chk({tag, "_done_err"}, done_err, exp_err);
    step();
    #1;
    chk({tag, "_done_width"}, done, 0);
    chk({tag, "_idle"}, busy, 0);
  endtask

  // Both requesters hold LOAD; 'first' is the requester the pointer favours
  task automatic arb_pair(input logic [W-1:0] a0, input logic [W-1:0] a1, input bit first,
                          input string tag);
    req0_valid = 1'b1; req0_op = OP_LOAD; req0_arg = a0;
    req1_valid = 1'b1; req1_op = OP_LOAD; req1_arg = a1;
    #1;
    chk({tag, "_ready0"}, req0_ready, !first);
    chk({tag, "_ready1"}, req1_ready, first);
    step();
    if (first) req1_valid = 1'b0; else req0_valid = 1'b0;
    #1;
    chk({tag, "_busy"}, busy, 1);
    chk({tag, "_no_ready_exec"}, first ? req0_ready : req1_ready, 0);
    step();
    #1;
    chk({tag, "_done_a"}, done, 1);
    chk({tag, "_id_a"}, done_id, first);
    chk({tag, "_q_a"}, done_q, first ? a1 : a0);
    step();
    #1;
    chk({tag, "_ready_other"}, first ? req0_ready : req1_ready, 1);
    step();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    step();
    #1;
    chk({tag, "_done_b"}, done, 1);
    chk({tag, "_id_b"}, done_id, !first);
    chk({tag, "_q_b"}, done_q, first ? a0 : a1);
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    stuck      = 1'b0;
    reset      = 1'b1;
    req0_valid = 1'b1; req0_op = OP_LOAD; req0_arg = 3'b011;
    req1_valid = 1'b1; req1_op = OP_LOAD; req1_arg = 3'b110;

    // Reset held with both valids high
    for (int c = 0; c < 3; c++) begin
      step();
      #1;
      chk("rst_ready0", req0_ready, 0);
      chk("rst_ready1", req1_ready, 0);
      chk("rst_done", done, 0);
      chk("rst_load", gc_load, 1);
      chk("rst_gc_in", gc_in, 0);
      chk("rst_up", gc_up, 1);
      chk("rst_busy", busy, 0);
      chk("rst_done_err", done_err, 0);
      chk("rst_done_q", done_q, 0);
      chk("rst_done_id", done_id, 0);
    end
    step();
    reset = 1'b0;

    arb_pair(3'b011, 3'b110, 1'b0, "arb1");

    run_cmd(1'b0, OP_LOAD, 3'b101, 2, 3'b101, 1'b0, "load101");
    repeat (3) step();
    chk("hold101", gc_q, 3'b101);

    run_cmd(1'b1, OP_UP,   3'd3, 5, 3'b001, 1'b0, "up3");
    run_cmd(1'b0, OP_DOWN, 3'd2, 4, 3'b100, 1'b0, "down2");
    run_cmd(1'b1, OP_UP,   3'd0, 2, 3'b100, 1'b0, "up0");

    // Pointer now favours req1
    run_cmd(1'b0, OP_LOAD, 3'b000, 2, 3'b000, 1'b0, "load000a");
    arb_pair(3'b011, 3'b101, 1'b1, "arb2");

    run_cmd(1'b0, OP_LOAD, 3'b000, 2, 3'b000, 1'b0, "load000b");
    run_cmd(1'b1, OP_SEEK, 3'b110, 6, 3'b110, 1'b0, "seek110");
    run_cmd(1'b0, OP_SEEK, 3'b110, 2, 3'b110, 1'b0, "seek_here");
    run_cmd(1'b0, OP_LOAD, 3'b000, 2, 3'b000, 1'b0, "load000c");
    stuck = 1'b1;
    run_cmd(1'b1, OP_SEEK, 3'b111, 10, 3'b000, 1'b1, "seek_limit");
    stuck = 1'b0;

    // Reset three steps into an UP 7 from req0
    req0_valid = 1'b1; req0_op = OP_UP; req0_arg = 3'd7;
    #1;
    chk("mr_ready", req0_ready, 1);
    step();
    req0_valid = 1'b0;
    #1;
    chk("mr_busy", busy, 1);
    chk("mr_done_t1", done, 0);
    for (int c = 0; c < 2; c++) begin
      step();
      #1;
      chk("mr_done_mid", done, 0);
    end
    step();
    reset = 1'b1;
    #1;
    chk("mr_q_after3", gc_q, 3'b010);
    chk("mr_rst_done", done, 0);
    chk("mr_rst_load", gc_load, 1);
    chk("mr_rst_gc_in", gc_in, 0);
    step();
    reset = 1'b0;
    req0_valid = 1'b1; req0_op = OP_LOAD; req0_arg = 3'b010;
    req1_valid = 1'b1; req1_op = OP_LOAD; req1_arg = 3'b111;
    #1;
    chk("mr_idle", busy, 0);
    chk("mr_no_done", done, 0);
    chk("mr_rr_ready0", req0_ready, 1);
    chk("mr_rr_ready1", req1_ready, 0);
    step();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    #1;
    chk("mr_load_in", gc_in, 3'b010);
    chk("mr_load_en", gc_load, 1);
    step();
    #1;
    chk("mr_done", done, 1);
    chk("mr_done_q", done_q, 3'b010);
    chk("mr_done_id", done_id, 0);
    chk("mr_done_err", done_err, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
